// File: rtl/float_add.sv
// Single-precision (binary32) floating-point adder with a start/valid handshake.
// One add at a time. The work is split over ALIGN, ADD, NORM and ROUND, and the
// packed result is registered on the edge that enters DONE. ROUND takes two
// cycles: the increment is computed in the first cycle, and the carry-out
// renormalisation, overflow/underflow check and packing happen in the second.
// This keeps the start-to-valid latency at five edges.
module float_add (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] X,
  input  logic [31:0] Y,
  output logic        valid,
  output logic [31:0] sum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_e;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_e state_q, state_d;

  // Latched operands.
  logic [31:0] x_q, y_q;

  // ALIGN outputs. Mantissas are {hidden, fraction[22:0], guard, round, sticky}.
  logic              special_q;
  logic [31:0]       special_val_q;
  logic              res_sign_q;
  logic              eff_sub_q;
  logic signed [9:0] exp_q;
  logic [26:0]       ma_q, mb_q;

  // ADD output: carry bit plus 27-bit magnitude.
  logic [27:0] add_q;

  // NORM outputs.
  logic [26:0] norm_q;
  logic        zero_q;

  // ROUND outputs.
  logic        round_step_q;
  logic [24:0] rnd_q;

  // Output registers.
  logic        valid_q;
  logic [31:0] sum_q;

  logic accept;
  assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // ---------------------------------------------------------------- unpack
  logic       sx, sy;
  logic [7:0] ex, ey;
  logic [22:0] fx, fy;
  logic x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, x_big;

  assign sx = x_q[31];
  assign sy = y_q[31];
  assign ex = x_q[30:23];
  assign ey = y_q[30:23];
  assign fx = x_q[22:0];
  assign fy = y_q[22:0];

  // A zero exponent field covers both zero and denormals; both are treated as zero.
  assign x_zero = (ex == 8'h00);
  assign y_zero = (ey == 8'h00);
  assign x_nan  = (ex == 8'hFF) && (fx != 23'd0);
  assign y_nan  = (ey == 8'hFF) && (fy != 23'd0);
  assign x_inf  = (ex == 8'hFF) && (fx == 23'd0);
  assign y_inf  = (ey == 8'hFF) && (fy == 23'd0);
  // On equal magnitudes X is taken as the larger operand. The difference is then zero.
  assign x_big  = ({ex, fx} >= {ey, fy});

  // ------------------------------------------------------------------ align
  logic [7:0]  ea, eb, diff;
  logic [22:0] fa, fb;
  logic [53:0] shift_full;
  logic [26:0] ma_d, mb_d;
  logic        special_d;
  logic [31:0] special_val_d;

  // Order the operands by magnitude, barrel-shift the smaller one, and resolve special cases.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    ea         = x_big ? ex : ey;
    eb         = x_big ? ey : ex;
    fa         = x_big ? fx : fy;
    fb         = x_big ? fy : fx;
    diff       = ea - eb;
    ma_d       = {1'b1, fa, 3'b000};
    shift_full = {1'b1, fb, 3'b000, 27'd0} >> diff;
    if (diff >= 8'd26) begin
      mb_d = 27'd1;
    end else begin
      mb_d = {shift_full[53:28], shift_full[27] | (|shift_full[26:0])};
    end

    special_d     = 1'b1;
    special_val_d = 32'd0;
    if (x_nan || y_nan || (x_inf && y_inf && (sx != sy))) begin
      special_val_d = QNAN;
    end else if (x_inf) begin
      special_val_d = {sx, 8'hFF, 23'd0};
    end else if (y_inf) begin
      special_val_d = {sy, 8'hFF, 23'd0};
    end else if (x_zero && y_zero) begin
      special_val_d = {sx & sy, 31'd0};
    end else if (x_zero) begin
      special_val_d = y_q;
    end else if (y_zero) begin
      special_val_d = x_q;
    end else begin
      special_d = 1'b0;
    end
  end

  // -------------------------------------------------------------------- add
  logic [27:0] add_d;

  // The larger magnitude is always in ma_q, so subtraction never goes negative.
  always_comb begin
    if (eff_sub_q) add_d = {1'b0, ma_q} - {1'b0, mb_q};
    else           add_d = {1'b0, ma_q} + {1'b0, mb_q};
  end

  // ------------------------------------------------------------------- norm
  logic [4:0]        lzc;
  logic              lz_found;
  logic [26:0]       norm_d;
  logic              zero_d;
  logic signed [9:0] norm_exp_d;

  // Carry-out shifts right once. Otherwise shift left by the leading-zero count of the magnitude.
  always_comb begin
    lzc      = 5'd0;
    lz_found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!lz_found && add_q[i]) begin
        lzc      = 5'(26 - i);
        lz_found = 1'b1;
      end
    end

    zero_d     = 1'b0;
    norm_d     = add_q[26:0];
    norm_exp_d = exp_q;
    if (add_q[27]) begin
      norm_d     = {add_q[27:2], add_q[1] | add_q[0]};
      norm_exp_d = exp_q + 10'sd1;
    end else if (!lz_found) begin
      zero_d = 1'b1;
    end else begin
      norm_d     = add_q[26:0] << lzc;
      norm_exp_d = exp_q - signed'({5'd0, lzc});
    end
  end

  // ------------------------------------------------------------------ round
  logic              round_up;
  logic [24:0]       rnd_d;
  logic signed [9:0] exp_fin;
  logic [22:0]       frac_fin;
  logic [31:0]       pack_d;

  // Round to nearest even, then renormalise on carry and pack with overflow/underflow handling.
  always_comb begin
    round_up = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
    rnd_d    = {1'b0, norm_q[26:3]} + {24'd0, round_up};

    exp_fin  = exp_q + (rnd_q[24] ? 10'sd1 : 10'sd0);
    frac_fin = rnd_q[24] ? rnd_q[23:1] : rnd_q[22:0];

    if (special_q) begin
      pack_d = special_val_q;
    end else if (zero_q) begin
      pack_d = 32'd0;
    end else if (exp_fin >= 10'sd255) begin
      pack_d = {res_sign_q, 8'hFF, 23'd0};
    end else if (exp_fin <= 10'sd0) begin
      pack_d = {res_sign_q, 31'd0};
    end else begin
      pack_d = {res_sign_q, exp_fin[7:0], frac_fin};
    end
  end

  // -------------------------------------------------------------------- fsm
  // Next-state logic: one pass through the stages per accepted start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ALIGN;
      S_ALIGN: state_d = S_ADD;
      S_ADD:   state_d = S_NORM;
      S_NORM:  state_d = S_ROUND;
      S_ROUND: if (round_step_q) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_ALIGN;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential blocks use non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Datapath registers: each stage loads its results while the FSM is in that stage.
  // NOTE: the datapath registers are reset too, so a reset clears the latched operands and all stage results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q           <= 32'd0;
      y_q           <= 32'd0;
      special_q     <= 1'b0;
      special_val_q <= 32'd0;
      res_sign_q    <= 1'b0;
      eff_sub_q     <= 1'b0;
      exp_q         <= 10'sd0;
      ma_q          <= 27'd0;
      mb_q          <= 27'd0;
      add_q         <= 28'd0;
      norm_q        <= 27'd0;
      zero_q        <= 1'b0;
      rnd_q         <= 25'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            x_q <= X;
            y_q <= Y;
          end
        end
        S_ALIGN: begin
          special_q     <= special_d;
          special_val_q <= special_val_d;
          res_sign_q    <= x_big ? sx : sy;
          eff_sub_q     <= sx ^ sy;
          exp_q         <= signed'({2'b00, ea});
          ma_q          <= ma_d;
          mb_q          <= mb_d;
        end
        S_ADD: add_q <= add_d;
        S_NORM: begin
          norm_q <= norm_d;
          zero_q <= zero_d;
          exp_q  <= norm_exp_d;
        end
        S_ROUND: if (!round_step_q) rnd_q <= rnd_d;
        default: ;
      endcase
    end
  end

  // Handshake and result registers: valid drops on an accepted start, and sum and valid load on ROUND -> DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      round_step_q <= 1'b0;
      valid_q      <= 1'b0;
      sum_q        <= 32'd0;
    end else begin
      round_step_q <= (state_q == S_ROUND) && !round_step_q;
      if (accept) begin
        valid_q <= 1'b0;
      end else if ((state_q == S_ROUND) && round_step_q) begin
        valid_q <= 1'b1;
        sum_q   <= pack_d;
      end
    end
  end

  assign valid = valid_q;
  assign sum   = sum_q;

endmodule

// File: tb/tb_float_add.sv
// Scoreboard bench for float_add. The stimulus pushes the expected sums and the monitor pops them on each valid rise.
module tb_float_add;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] X, Y;
  logic        valid;
  logic [31:0] sum;

  float_add dut (
    .clk  (clk),
    .rst  (rst_n),
    .start(start),
    .X    (X),
    .Y    (Y),
    .valid(valid),
    .sum  (sum)
  );

  typedef struct {
    logic [31:0] exp_sum;
    int          issue;
    string       name;
  } sb_t;

  sb_t         sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [31:0] prev_sum = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp_v);
    end
  endtask

  // Monitor: on each rising valid, compare sum and latency against the oldest expectation.
  initial begin
    logic valid_prev;
    sb_t  e;
    valid_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (valid === 1'b1 && valid_prev !== 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check({"sum_", e.name}, sum, e.exp_sum);
          check({"latency_", e.name}, 32'(cyc - e.issue), 32'd5);
        end
      end
      valid_prev = valid;
    end
  end

  // Issue one add. Optionally pulse start again mid-operation (it must be ignored).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_v,
                        input string nm, input bit poke);
    sb_t e;
    bit  seen;
    @(negedge clk);
    X = a; Y = b; start = 1'b1;
    @(posedge clk); #1;
    e.exp_sum = exp_v; e.issue = cyc; e.name = nm;
    sb_q.push_back(e);
    check({"valid_clr_", nm}, {31'd0, valid}, 32'd0);
    check({"sum_hold_", nm}, sum, prev_sum);
    @(negedge clk);
    start = 1'b0;
    X = $urandom; Y = $urandom;
    if (poke) begin
      @(negedge clk);
      start = 1'b1; X = 32'h4120_0000; Y = 32'h4120_0000;
      @(negedge clk);
      start = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (valid === 1'b1) seen = 1'b1;
    end
    if (!seen) check({"timeout_", nm}, {31'd0, valid}, 32'd1);
    prev_sum = exp_v;
    @(negedge clk);
  endtask

  initial begin
    start = 1'b0; X = 32'd0; Y = 32'd0;
    rst_n = 1'b0;
    #2;
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_sum", sum, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    run_op(32'h4070_0000, 32'hC0D8_0000, 32'hC040_0000, "neg3", 1'b0);
    run_op(32'h40D8_0000, 32'h4070_0000, 32'h4128_0000, "b2b_10p5", 1'b0);
    run_op(32'h40D8_0000, 32'hC070_0000, 32'h4040_0000, "pos_neg", 1'b0);
    run_op(32'hC0D8_0000, 32'h4070_0000, 32'hC040_0000, "neg_pos", 1'b0);
    run_op(32'hC0D8_0000, 32'hC070_0000, 32'hC128_0000, "neg_neg", 1'b0);
    run_op(32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, "cancel", 1'b0);
    run_op(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, "inf_minus_inf", 1'b0);
    run_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, "overflow", 1'b0);
    run_op(32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, "tie_even", 1'b0);
    run_op(32'h3F80_0000, 32'h3380_0001, 32'h3F80_0001, "above_tie", 1'b0);
    run_op(32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000, "zero_operand", 1'b0);
    run_op(32'h3F7F_FFFF, 32'h3300_0000, 32'h3F80_0000, "round_carry", 1'b0);
    run_op(32'h4C80_0000, 32'hBF80_0000, 32'h4C80_0000, "far_sticky", 1'b0);
    run_op(32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, "inf_finite", 1'b0);
    run_op(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, "nan_in", 1'b0);
    run_op(32'h8000_0001, 32'h8000_0000, 32'h8000_0000, "neg_zeros", 1'b0);
    run_op(32'h0000_0001, 32'h8000_0000, 32'h0000_0000, "mixed_zeros", 1'b0);
    run_op(32'h0080_0001, 32'h8080_0000, 32'h0000_0000, "underflow", 1'b0);
    run_op(32'h4070_0000, 32'h40D8_0000, 32'h4128_0000, "start_ignored", 1'b1);

    // Reset in the middle of an operation, while sum still holds a nonzero result.
    @(negedge clk);
    X = 32'h3F80_0000; Y = 32'h3F80_0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midop_reset_valid", {31'd0, valid}, 32'd0);
    check("midop_reset_sum", sum, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("idle_after_reset", {31'd0, valid}, 32'd0);
    prev_sum = 32'd0;
    run_op(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, "after_reset", 1'b0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
